// File: rtl/pixel_frame_sched.sv
// Frame scheduler for the pixel AXI4 write master: per-transaction addressing,
// ping-pong frame buffers, outstanding-write throttling and B-response tracking.
module pixel_frame_sched #(
    parameter int ADDR_W        = 32,
    parameter int TXN_BYTES     = 76800,
    parameter int TXN_PER_FRAME = 4,
    parameter int MAX_OUTS      = 2,
    parameter int FCNT_W        = 16,
    parameter int TRANS_RESP_W  = 2
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    cfg_en_i,
    input  logic [ADDR_W-1:0]       cfg_base0_i,
    input  logic [ADDR_W-1:0]       cfg_base1_i,
    input  logic                    cfg_err_clr_i,
    input  logic                    pdf_vld_i,
    output logic                    pdf_rdy_o,
    output logic                    tx_vld_o,
    input  logic                    tx_rdy_i,
    output logic [ADDR_W-1:0]       tx_addr_o,
    input  logic                    s_awvalid_i,
    input  logic                    s_awready_i,
    input  logic                    s_wvalid_i,
    input  logic                    s_wready_i,
    input  logic                    s_wlast_i,
    input  logic                    s_bvalid_i,
    input  logic [TRANS_RESP_W-1:0] s_bresp_i,
    output logic                    s_bready_o,
    output logic                    frame_done_o,
    output logic                    buf_sel_o,
    output logic [FCNT_W-1:0]       frame_cnt_o,
    output logic                    err_o
);

    localparam int OUTS_W = $clog2(MAX_OUTS + 1);
    localparam int TXN_W  = $clog2(TXN_PER_FRAME + 1);
    localparam logic [OUTS_W-1:0] MAX_OUTS_C = OUTS_W'(MAX_OUTS);
    localparam logic [TXN_W-1:0]  TXN_LAST   = TXN_W'(TXN_PER_FRAME);
    localparam logic [TXN_W-1:0]  TXN_FINAL  = TXN_W'(TXN_PER_FRAME - 1);
    localparam logic [ADDR_W-1:0] TXN_STEP   = ADDR_W'(TXN_BYTES);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_RUN,
        ST_DRAIN
    } state_t;

    state_t              r_state;
    state_t              w_state_next;
    logic [OUTS_W-1:0]   r_outs;
    logic [OUTS_W-1:0]   w_outs_next;
    logic [TXN_W-1:0]    r_txn_cnt;
    logic [ADDR_W-1:0]   r_addr;
    logic [FCNT_W-1:0]   r_fcnt;
    logic                r_w_busy;
    logic                r_buf_sel;
    logic                r_err;
    logic                r_frame_done;
    logic                r_bready;

    logic w_aw_hsk;
    logic w_b_hsk;
    logic w_b_dec;
    logic w_wl_hsk;
    logic w_px_hsk;
    logic w_gate;
    logic w_frame_end;

    assign w_aw_hsk = s_awvalid_i & s_awready_i;
    assign w_b_hsk  = s_bvalid_i & r_bready;
    assign w_wl_hsk = s_wvalid_i & s_wready_i & s_wlast_i;
    assign w_px_hsk = tx_vld_o & tx_rdy_i;
    // A stray B with nothing outstanding must not underflow the counter.
    assign w_b_dec  = w_b_hsk & (r_outs != '0);

    // w_busy keeps the gate open until the transaction's last W beat is taken.
    assign w_gate = r_w_busy |
                    ((r_state == ST_RUN) & (r_outs < MAX_OUTS_C) & (r_txn_cnt < TXN_LAST));

    assign tx_vld_o  = pdf_vld_i & w_gate;
    assign pdf_rdy_o = tx_rdy_i & w_gate;

    always_comb begin
        w_outs_next = r_outs;
        if (w_aw_hsk && !w_b_dec) begin
            w_outs_next = r_outs + OUTS_W'(1);
        end else if (!w_aw_hsk && w_b_dec) begin
            w_outs_next = r_outs - OUTS_W'(1);
        end
    end

    // Completion uses the post-update count so done follows the last B by one cycle.
    assign w_frame_end = (r_state == ST_DRAIN) & (w_outs_next == '0) & ~r_w_busy;

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            ST_IDLE:  if (cfg_en_i) w_state_next = ST_RUN;
            ST_RUN:   if (w_aw_hsk && (r_txn_cnt == TXN_FINAL)) w_state_next = ST_DRAIN;
            ST_DRAIN: if (w_frame_end) w_state_next = cfg_en_i ? ST_RUN : ST_IDLE;
            default:  w_state_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_outs       <= '0;
            r_txn_cnt    <= '0;
            r_addr       <= '0;
            r_fcnt       <= '0;
            r_w_busy     <= 1'b0;
            r_buf_sel    <= 1'b0;
            r_err        <= 1'b0;
            r_frame_done <= 1'b0;
            r_bready     <= 1'b0;
        end else begin
            r_bready     <= 1'b1;
            r_frame_done <= w_frame_end;
            r_outs       <= w_outs_next;

            if (w_wl_hsk) begin
                r_w_busy <= 1'b0;
            end else if (w_px_hsk) begin
                r_w_busy <= 1'b1;
            end

            if (w_b_hsk && (s_bresp_i != '0)) begin
                r_err <= 1'b1;
            end else if (cfg_err_clr_i) begin
                r_err <= 1'b0;
            end

            case (r_state)
                ST_IDLE: begin
                    r_addr    <= r_buf_sel ? cfg_base1_i : cfg_base0_i;
                    r_txn_cnt <= '0;
                end
                ST_RUN: begin
                    if (w_aw_hsk) begin
                        r_addr    <= r_addr + TXN_STEP;
                        r_txn_cnt <= r_txn_cnt + TXN_W'(1);
                    end
                end
                ST_DRAIN: begin
                    if (w_frame_end) begin
                        r_buf_sel <= ~r_buf_sel;
                        r_fcnt    <= r_fcnt + FCNT_W'(1);
                        r_addr    <= r_buf_sel ? cfg_base0_i : cfg_base1_i;
                        r_txn_cnt <= '0;
                    end
                end
                default: begin
                    r_txn_cnt <= '0;
                end
            endcase
        end
    end

    assign tx_addr_o    = r_addr;
    assign buf_sel_o    = r_buf_sel;
    assign frame_cnt_o  = r_fcnt;
    assign err_o        = r_err;
    assign frame_done_o = r_frame_done;
    assign s_bready_o   = r_bready;

endmodule

// File: tb/tb_pixel_frame_sched.sv
// Randomized bench for pixel_frame_sched: a frame-level reference model predicts
// every output each cycle; phases bias the traffic toward the interesting corners.
module tb_pixel_frame_sched;

    localparam int ADDR_W        = 32;
    localparam int TXN_BYTES     = 76800;
    localparam int TXN_PER_FRAME = 4;
    localparam int MAX_OUTS      = 2;
    localparam int FCNT_W        = 16;
    localparam int TRANS_RESP_W  = 2;
    localparam int N_CYC         = 8000;

    logic                    clk;
    logic                    rst_n;
    logic                    cfg_en_i;
    logic [ADDR_W-1:0]       cfg_base0_i;
    logic [ADDR_W-1:0]       cfg_base1_i;
    logic                    cfg_err_clr_i;
    logic                    pdf_vld_i;
    logic                    pdf_rdy_o;
    logic                    tx_vld_o;
    logic                    tx_rdy_i;
    logic [ADDR_W-1:0]       tx_addr_o;
    logic                    s_awvalid_i;
    logic                    s_awready_i;
    logic                    s_wvalid_i;
    logic                    s_wready_i;
    logic                    s_wlast_i;
    logic                    s_bvalid_i;
    logic [TRANS_RESP_W-1:0] s_bresp_i;
    logic                    s_bready_o;
    logic                    frame_done_o;
    logic                    buf_sel_o;
    logic [FCNT_W-1:0]       frame_cnt_o;
    logic                    err_o;

    pixel_frame_sched #(
        .ADDR_W(ADDR_W), .TXN_BYTES(TXN_BYTES), .TXN_PER_FRAME(TXN_PER_FRAME),
        .MAX_OUTS(MAX_OUTS), .FCNT_W(FCNT_W), .TRANS_RESP_W(TRANS_RESP_W)
    ) dut (
        .clk(clk), .rst_n(rst_n), .cfg_en_i(cfg_en_i),
        .cfg_base0_i(cfg_base0_i), .cfg_base1_i(cfg_base1_i), .cfg_err_clr_i(cfg_err_clr_i),
        .pdf_vld_i(pdf_vld_i), .pdf_rdy_o(pdf_rdy_o), .tx_vld_o(tx_vld_o), .tx_rdy_i(tx_rdy_i),
        .tx_addr_o(tx_addr_o), .s_awvalid_i(s_awvalid_i), .s_awready_i(s_awready_i),
        .s_wvalid_i(s_wvalid_i), .s_wready_i(s_wready_i), .s_wlast_i(s_wlast_i),
        .s_bvalid_i(s_bvalid_i), .s_bresp_i(s_bresp_i), .s_bready_o(s_bready_o),
        .frame_done_o(frame_done_o), .buf_sel_o(buf_sel_o), .frame_cnt_o(frame_cnt_o),
        .err_o(err_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_total = 0;
    int n_bad   = 0;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
        end
    endtask

    // Reference model: a frame is "active" with some number of AWs issued so far;
    // once all are issued it waits for the write side to go quiet.
    bit          m_active;
    int          m_issued;
    int          m_outs;
    bit          m_busy;
    bit          m_buf;
    int          m_fcnt;
    bit          m_err;
    bit          m_done;
    bit          m_bready;
    logic [31:0] m_base;
    int          m_frames;

    function automatic bit m_gate();
        return m_busy || (m_active && (m_issued < TXN_PER_FRAME) && (m_outs < MAX_OUTS));
    endfunction

    function automatic logic [31:0] m_addr();
        logic [31:0] off;
        off = 32'(m_issued) * 32'(TXN_BYTES);
        return m_base + off;
    endfunction

    function automatic bit rnd(input int pct);
        return ($urandom_range(0, 99) < pct);
    endfunction

    task automatic model_reset();
        m_active = 0; m_issued = 0; m_outs = 0; m_busy = 0; m_buf = 0;
        m_fcnt = 0; m_err = 0; m_done = 0; m_bready = 0; m_base = '0;
    endtask

    task automatic model_step();
        bit aw, b, wl, px, bdec, g;
        int outs_n;
        if (!rst_n) begin
            model_reset();
            return;
        end
        g      = m_gate();
        aw     = s_awvalid_i && s_awready_i;
        b      = s_bvalid_i && m_bready;
        wl     = s_wvalid_i && s_wready_i && s_wlast_i;
        px     = pdf_vld_i && g && tx_rdy_i;
        bdec   = b && (m_outs > 0);
        outs_n = m_outs + (aw ? 1 : 0) - (bdec ? 1 : 0);
        m_done = 0;
        if (!m_active) begin
            m_base   = m_buf ? cfg_base1_i : cfg_base0_i;
            m_issued = 0;
            if (cfg_en_i) m_active = 1;
        end else if (m_issued < TXN_PER_FRAME) begin
            if (aw) m_issued++;
        end else if (outs_n == 0 && !m_busy) begin
            m_done   = 1;
            m_buf    = !m_buf;
            m_fcnt++;
            m_frames++;
            m_base   = m_buf ? cfg_base1_i : cfg_base0_i;
            m_issued = 0;
            m_active = cfg_en_i;
            $display("frame %0d complete, next buffer %0d, err=%0d", m_fcnt, m_buf, m_err);
        end
        if (b && (s_bresp_i != '0)) m_err = 1;
        else if (cfg_err_clr_i)     m_err = 0;
        if (wl)      m_busy = 0;
        else if (px) m_busy = 1;
        m_outs   = outs_n;
        m_bready = 1;
    endtask

    initial begin
        int phase;
        int p_aw, p_b, p_wl, p_err, p_clr, p_rst, p_en_flip;
        m_frames      = 0;
        rst_n         = 1'b0;
        cfg_en_i      = 1'b0;
        cfg_base0_i   = 32'h1000_0000;
        cfg_base1_i   = 32'h2000_0000;
        cfg_err_clr_i = 1'b0;
        pdf_vld_i     = 1'b0;
        tx_rdy_i      = 1'b0;
        s_awvalid_i   = 1'b0;
        s_awready_i   = 1'b0;
        s_wvalid_i    = 1'b0;
        s_wready_i    = 1'b0;
        s_wlast_i     = 1'b0;
        s_bvalid_i    = 1'b0;
        s_bresp_i     = '0;
        model_reset();

        for (int cyc = 0; cyc < N_CYC; cyc++) begin
            phase = cyc / 2000;
            // phase 0: clean traffic; 1: B starved; 2: error responses; 3: enable toggling
            p_aw      = 30;
            p_b       = (phase == 1) ? 4 : 40;
            p_wl      = 15;
            p_err     = (phase == 2) ? 25 : 0;
            p_clr     = (phase == 2) ? 10 : 1;
            p_rst     = 1;
            p_en_flip = (phase == 3) ? 3 : 0;

            if (cyc > 0) begin
                chk("tx_addr",   tx_addr_o,    m_addr());
                chk("buf_sel",   buf_sel_o,    m_buf);
                chk("frame_cnt", frame_cnt_o,  FCNT_W'(m_fcnt));
                chk("err",       err_o,        m_err);
                chk("frame_done", frame_done_o, m_done);
                chk("bready",    s_bready_o,   m_bready);
            end

            if (cyc < 3)              rst_n = 1'b0;
            else                      rst_n = !(rnd(p_rst) && (cyc % 5 == 0));
            if (cyc == 4)             cfg_en_i = 1'b1;
            else if (rnd(p_en_flip))  cfg_en_i = !cfg_en_i;
            else if (phase != 3 && cyc > 4) cfg_en_i = 1'b1;
            if (rnd(1)) cfg_base0_i = $urandom() & 32'hFFFF_FF00;
            if (rnd(1)) cfg_base1_i = $urandom() & 32'hFFFF_FF00;
            pdf_vld_i     = rnd(70);
            tx_rdy_i      = rnd(70);
            s_awvalid_i   = (m_outs < MAX_OUTS) && rnd(p_aw);
            s_awready_i   = s_awvalid_i && rnd(80);
            s_wvalid_i    = rnd(60);
            s_wready_i    = rnd(70);
            s_wlast_i     = rnd(p_wl);
            s_bvalid_i    = (m_outs > 0) && rnd(p_b);
            s_bresp_i     = rnd(p_err) ? TRANS_RESP_W'($urandom_range(1, 3)) : '0;
            cfg_err_clr_i = rnd(p_clr);

            #1;
            if (cyc > 0) begin
                chk("tx_vld",  tx_vld_o,  pdf_vld_i && m_gate());
                chk("pdf_rdy", pdf_rdy_o, tx_rdy_i && m_gate());
            end
            model_step();
            @(negedge clk);
        end

        chk("frames_progress", (m_frames >= 20), 1'b1);
        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule

// File: doc/pixel_frame_sched.md
Name: pixel_frame_sched

Overview:
- Frame-level scheduler for the pixel AXI4 write master. It sits between the pixel downscaler FIFO, the DVP configuration register and the pixel AXI4 TX engine.
- It generates the per-transaction write address and ping-pongs between two frame buffers.
- It throttles the pixel stream at transaction boundaries, bounds outstanding writes, collects B responses and reports frame completion and errors.

Parameters:
ADDR_W, 32, address width
TXN_BYTES, 76800, bytes per AXI4 transaction (19200 beats x 4 B); added to the address after each AW handshake
TXN_PER_FRAME, 4, transactions per frame
MAX_OUTS, 2, maximum AW-issued-but-B-not-received transactions (>=1)
FCNT_W, 16, frame counter width
TRANS_RESP_W, 2, BRESP width

Ports:
clk  in  1  clock
rst_n  in  1  reset, synchronous, active-low
cfg_en_i  in  1  enable frame capture (level)
cfg_base0_i  in  ADDR_W  frame buffer 0 base
cfg_base1_i  in  ADDR_W  frame buffer 1 base
cfg_err_clr_i  in  1  clear sticky error (pulse)
pdf_vld_i  in  1  pixel valid from downscaler FIFO
pdf_rdy_o  out  1  pixel ready to downscaler FIFO
tx_vld_o  out  1  gated pixel valid to TX engine
tx_rdy_i  in  1  pixel ready from TX engine
tx_addr_o  out  ADDR_W  transaction address to TX engine
s_awvalid_i  in  1  AW valid (monitored)
s_awready_i  in  1  AW ready (monitored)
s_wvalid_i  in  1  W valid (monitored)
s_wready_i  in  1  W ready (monitored)
s_wlast_i  in  1  W last (monitored)
s_bvalid_i  in  1  B valid from slave
s_bresp_i  in  TRANS_RESP_W  B response
s_bready_o  out  1  B ready to slave
frame_done_o  out  1  one-cycle pulse, frame fully acknowledged
buf_sel_o  out  1  buffer currently being written
frame_cnt_o  out  FCNT_W  completed frames, wraps
err_o  out  1  sticky: any BRESP != 0

Behaviour:
- Reset (rst_n=0 at a clk edge):
  - State is IDLE.
  - tx_addr_o=0, buf_sel_o=0, frame_cnt_o=0, err_o=0, frame_done_o=0, s_bready_o=0.
  - Outstanding count=0, txn count=0, w_busy=0.
  - The same applies when reset is asserted mid-frame; no partial state survives.
- s_bready_o is registered and equals 1 from the first cycle after reset release.
- Events:
  - aw_hsk = s_awvalid_i & s_awready_i
  - b_hsk = s_bvalid_i & s_bready_o
  - wl_hsk = s_wvalid_i & s_wready_i & s_wlast_i
  - px_hsk = tx_vld_o & tx_rdy_i
- Outstanding counter:
  - +1 on aw_hsk, -1 on b_hsk; unchanged when both occur in the same cycle.
  - Width is clog2(MAX_OUTS+1).
  - A b_hsk with count 0 is ignored.
- w_busy:
  - Set on px_hsk while clear.
  - Cleared on wl_hsk; wl_hsk wins when both occur in the same cycle.
- Gate (combinational): gate = w_busy | (state==RUN & outs<MAX_OUTS & txn_cnt_issued<TXN_PER_FRAME).
  - tx_vld_o = pdf_vld_i & gate.
  - pdf_rdy_o = tx_rdy_i & gate.
  - The gate never closes mid-transaction.
- State IDLE:
  - tx_addr_o <= buf_sel ? cfg_base1_i : cfg_base0_i every cycle.
  - cfg_en_i=1 -> RUN. txn_cnt=0.
- State RUN:
  - On aw_hsk: tx_addr_o += TXN_BYTES (mod 2^ADDR_W), txn_cnt++.
  - When the aw_hsk brings txn_cnt to TXN_PER_FRAME -> DRAIN.
  - cfg_en_i falling in RUN does not abort; the frame completes.
- State DRAIN:
  - The gate is closed except for w_busy.
  - Wait for outs==0 & ~w_busy.
  - Then, in one cycle: frame_done_o=1 (next cycle), buf_sel toggles, frame_cnt++ (wraps), tx_addr_o <= new buffer base, txn_cnt=0.
  - Next state is RUN if cfg_en_i=1, else IDLE.
- Error handling:
  - err_o is set on b_hsk with s_bresp_i!=0.
  - It is cleared by cfg_err_clr_i; set wins when both occur in the same cycle.
  - An error does not stop scheduling.
- Latency: the address update is visible on the cycle after aw_hsk. frame_done_o is asserted the cycle after the last B is accepted, provided w_busy=0.

Test Plan:
- Reset then cfg_base0=0x1000_0000, cfg_base1=0x2000_0000, cfg_en=1, 4 transactions with immediate B -> tx_addr_o steps 0x1000_0000, 0x1001_2C00, 0x1002_5800, 0x1003_8400. After the 4th B: frame_done_o pulses 1 cycle, buf_sel_o=1, tx_addr_o=0x2000_0000, frame_cnt_o=1.
- B withheld, MAX_OUTS=2 -> after 2 aw_hsk and both wl_hsk, tx_vld_o=0 and pdf_rdy_o=0 with pdf_vld_i=1. One B accepted -> gate reopens next cycle.
- aw_hsk and b_hsk in the same cycle with outs=1 -> outs stays 1. The 4th AW is followed by W beats: the gate stays open via w_busy until wl_hsk, then closes in DRAIN.
- BRESP=2'b10 on the 2nd B -> err_o=1 from the next cycle, frame still completes. cfg_err_clr_i pulse with no concurrent error -> err_o=0. Clear together with a new error -> err_o stays 1.
- cfg_en_i dropped during RUN of frame 0 -> the frame completes, frame_done_o pulses, state returns to IDLE, tx_addr_o tracks cfg_base1_i.
- rst_n=0 for one cycle mid-frame with outs=2 -> all outputs return to reset values. tx_addr_o=0 and s_bready_o=0 during reset; s_bready_o=1 the following cycle.
